// File: rtl/hilo_issue_ctrl_pkg.sv
// Shared HI/LO op encodings, default latencies and FSM state type for the
// HI/LO issue controller and its op classifier.
package hilo_issue_ctrl_pkg;

  localparam logic [3:0] OP_NONE  = 4'h0;
  localparam logic [3:0] OP_MULT  = 4'h1;
  localparam logic [3:0] OP_MULTU = 4'h2;
  localparam logic [3:0] OP_DIV   = 4'h3;
  localparam logic [3:0] OP_DIVU  = 4'h4;
  localparam logic [3:0] OP_MFHI  = 4'h5;
  localparam logic [3:0] OP_MFLO  = 4'h6;
  localparam logic [3:0] OP_MTHI  = 4'h7;
  localparam logic [3:0] OP_MTLO  = 4'h8;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/hilo_issue_ctrl_op_class.sv
// Combinational HI/LO op classifier: start-class, hilo-class and the busy
// latency a start-class op would load into the shadow counter.
module hilo_op_class
  import hilo_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic [3:0]       op_i,
  output logic             is_start_o,
  output logic             is_hilo_o,
  output logic [CNT_W-1:0] lat_o
);

  always_comb begin
    is_start_o = 1'b0;
    is_hilo_o  = 1'b0;
    lat_o      = '0;
    case (op_i)
      OP_MULT, OP_MULTU: begin
        is_start_o = 1'b1;
        is_hilo_o  = 1'b1;
        lat_o      = CNT_W'(MUL_LAT);
      end
      OP_DIV, OP_DIVU: begin
        is_start_o = 1'b1;
        is_hilo_o  = 1'b1;
        lat_o      = CNT_W'(DIV_LAT);
      end
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: begin
        is_hilo_o = 1'b1;
      end
      default: begin
        is_start_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hilo_issue_ctrl.sv
// HI/LO issue/interlock controller: gated start strobe, shadow busy counter,
// D-stage stall and sticky busy consistency flag. HILO_STALL_CNT_EN adds stall_cnt.
module hilo_issue_ctrl
  import hilo_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_valid,
  input  logic [3:0]  D_HILOOp,
  input  logic        E_valid,
  input  logic [3:0]  E_HILOOp,
  input  logic        Req,
  input  logic        md_busy,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic        Stall,
  output logic        busy_err
`ifdef HILO_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic             d_start_unused;
  logic             d_hilo;
  logic [CNT_W-1:0] d_lat_unused;
  logic             e_start;
  logic             e_hilo_unused;
  logic [CNT_W-1:0] e_lat;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             busy_err_q, busy_err_d;
  logic             cnt_nz;

  hilo_op_class #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_d_class (
    .op_i       (D_HILOOp),
    .is_start_o (d_start_unused),
    .is_hilo_o  (d_hilo),
    .lat_o      (d_lat_unused)
  );

  hilo_op_class #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_e_class (
    .op_i       (E_HILOOp),
    .is_start_o (e_start),
    .is_hilo_o  (e_hilo_unused),
    .lat_o      (e_lat)
  );

  assign cnt_nz = (cnt_q != '0);

  // Gating with reset keeps start and stall low while reset is held low.
  assign md_start = reset & E_valid & e_start & ~Req & ~cnt_nz;
  assign md_op    = (E_valid & ~Req) ? E_HILOOp : OP_NONE;
  assign Stall    = reset & D_valid & d_hilo & (md_start | cnt_nz);
  assign busy_err = busy_err_q;

  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    busy_err_d = busy_err_q;
    if (md_start) begin
      cnt_d = e_lat;
    end else if (!Req && cnt_nz) begin
      cnt_d = cnt_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_RUN;
      ST_RUN:  if (!Req && cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A start-class op reaching E while the unit is busy means the interlock leaked.
    if ((cnt_nz != md_busy) || (E_valid && e_start && cnt_nz)) begin
      busy_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      busy_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      busy_err_q <= busy_err_d;
    end
  end

`ifdef HILO_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 32'(Stall);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// Scoreboard bench for hilo_issue_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares.
module tb_hilo_issue_ctrl;
  import hilo_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        D_valid = 1'b0;
  logic [3:0]  D_HILOOp = OP_NONE;
  logic        E_valid = 1'b0;
  logic [3:0]  E_HILOOp = OP_NONE;
  logic        Req = 1'b0;
  logic        md_busy = 1'b0;
  logic        md_start;
  logic [3:0]  md_op;
  logic        Stall;
  logic        busy_err;
`ifdef HILO_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hilo_issue_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .D_valid  (D_valid),
    .D_HILOOp (D_HILOOp),
    .E_valid  (E_valid),
    .E_HILOOp (E_HILOOp),
    .Req      (Req),
    .md_busy  (md_busy),
    .md_start (md_start),
    .md_op    (md_op),
    .Stall    (Stall),
    .busy_err (busy_err)
`ifdef HILO_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       start;
    logic [3:0] op;
    logic       stall;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   vecId = 0;

  localparam logic [3:0] N = OP_NONE;

  task automatic checkOutput(input string name, input int id,
                             input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, id, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic dv, input logic [3:0] dop,
                               input logic ev, input logic [3:0] eop,
                               input logic rq, input logic bsy,
                               input logic xStart, input logic [3:0] xOp,
                               input logic xStall, input logic xErr);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rstn;
    D_valid  = dv;
    D_HILOOp = dop;
    E_valid  = ev;
    E_HILOOp = eop;
    Req      = rq;
    md_busy  = bsy;
    e.id     = vecId;
    e.start  = xStart;
    e.op     = xOp;
    e.stall  = xStall;
    e.err    = xErr;
    expQ.push_back(e);
    vecId++;
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      checkOutput("md_start", monE.id, 32'(md_start), 32'(monE.start));
      checkOutput("md_op",    monE.id, 32'(md_op),    32'(monE.op));
      checkOutput("Stall",    monE.id, 32'(Stall),    32'(monE.stall));
      checkOutput("busy_err", monE.id, 32'(busy_err), 32'(monE.err));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // reset held: start/stall gated, md_op still passes through
    applyStimulus(0, 1, OP_MFLO, 1, OP_MULT, 0, 0,  0, OP_MULT, 0, 0);
    applyStimulus(1, 0, N, 0, N, 0, 0,              0, N, 0, 0);

    // mult with mflo waiting in D: 6 stall cycles
    applyStimulus(1, 1, OP_MFLO, 1, OP_MULT, 0, 0,  1, OP_MULT, 1, 0);
    repeat (5) applyStimulus(1, 1, OP_MFLO, 0, N, 0, 1, 0, N, 1, 0);
    applyStimulus(1, 1, OP_MFLO, 0, N, 0, 0,        0, N, 0, 0);

    // div with Req frozen 3 cycles at cnt=6: 14 stall cycles
    applyStimulus(1, 1, OP_MFHI, 1, OP_DIV, 0, 0,   1, OP_DIV, 1, 0);
    repeat (4) applyStimulus(1, 1, OP_MFHI, 0, N, 0, 1, 0, N, 1, 0);
    applyStimulus(1, 1, OP_MFHI, 1, OP_MTHI, 1, 1,  0, N, 1, 0);
    repeat (2) applyStimulus(1, 1, OP_MFHI, 0, N, 1, 1, 0, N, 1, 0);
    repeat (6) applyStimulus(1, 1, OP_MFHI, 0, N, 0, 1, 0, N, 1, 0);
    applyStimulus(1, 1, OP_MFHI, 0, N, 0, 0,        0, N, 0, 0);

    // multu blocked by Req: no start, counter stays idle
    applyStimulus(1, 0, N, 1, OP_MULTU, 1, 0,       0, N, 0, 0);
    applyStimulus(1, 1, OP_MFHI, 0, N, 0, 0,        0, N, 0, 0);
    applyStimulus(1, 1, OP_MFHI, 1, OP_MFHI, 0, 0,  0, OP_MFHI, 0, 0);

    // unit drops busy one cycle early: sticky busy_err until reset
    applyStimulus(1, 0, N, 1, OP_MULT, 0, 0,        1, OP_MULT, 0, 0);
    repeat (4) applyStimulus(1, 0, N, 0, N, 0, 1,   0, N, 0, 0);
    applyStimulus(1, 0, N, 0, N, 0, 0,              0, N, 0, 0);
    repeat (3) applyStimulus(1, 0, N, 0, N, 0, 0,   0, N, 0, 1);
    applyStimulus(1, 1, OP_MFLO, 0, N, 0, 0,        0, N, 0, 1);
    applyStimulus(0, 0, N, 0, N, 0, 0,              0, N, 0, 0);

    // illegal start while busy, then async reset at cnt=3
    applyStimulus(1, 1, OP_MFLO, 1, OP_MULT, 0, 0,  1, OP_MULT, 1, 0);
    applyStimulus(1, 1, OP_MFLO, 1, OP_MULT, 0, 1,  0, OP_MULT, 1, 0);
    applyStimulus(1, 1, OP_MFLO, 0, N, 0, 1,        0, N, 1, 1);
    applyStimulus(0, 1, OP_MFLO, 0, N, 0, 1,        0, N, 0, 0);
    applyStimulus(1, 1, OP_MFLO, 0, N, 0, 0,        0, N, 0, 0);
`ifdef HILO_STALL_CNT_EN
    @(negedge clk);
    checkOutput("stall_cnt", vecId - 1, stall_cnt, 32'd0);
`endif
    applyStimulus(1, 0, N, 0, N, 0, 0,              0, N, 0, 0);

    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
